// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-32 fetch path: address width default,
// instruction word width and the fetch sequencer state encoding.
package mips_pkg;

   localparam int ADDR_W_DEF = 7;
   localparam int INSTR_W    = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   function automatic logic word_aligned(input logic [1:0] lsb);
      return lsb == 2'b00;
   endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bus: instruction memory read port, redirect request and the
// valid/ready slot presented to decode.
interface ifetch_ctrl_if #(
   parameter int ADDR_W = mips_pkg::ADDR_W_DEF
);
   import mips_pkg::*;

   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_data;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_target;
   logic               if_valid;
   logic               if_ready;
   logic [INSTR_W-1:0] if_instr;
   logic [ADDR_W-1:0]  if_pc;
   logic [ADDR_W-1:0]  if_pc4;

   modport master (
      output imem_addr,
      input  imem_data,
      input  redirect_valid,
      input  redirect_target,
      output if_valid,
      input  if_ready,
      output if_instr,
      output if_pc,
      output if_pc4
   );

   modport slave (
      input  imem_addr,
      output imem_data,
      output redirect_valid,
      output redirect_target,
      input  if_valid,
      output if_ready,
      input  if_instr,
      input  if_pc,
      input  if_pc4
   );

endinterface

// File: rtl/ifetch_ctrl_pc_reg.sv
// Program counter register: load has priority over increment, otherwise hold.
// Arithmetic wraps naturally at 2^ADDR_W.
module pc_reg #(
   parameter int ADDR_W   = 7,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_val;
      end else if (inc) begin
         pc_d = pc_q + ADDR_W'(4);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= ADDR_W'(RESET_PC);
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, registers the memory word into a
// single valid/ready slot, and handles redirects, stalls and end-of-program.
//
// state   | meaning
// IDLE    | waiting for run, no fetch
// RUN     | fetching while PC <= LAST_PC
// HALT    | past end of program or misaligned redirect; only a redirect leaves
module ifetch_ctrl
   import mips_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int RESET_PC = 0,
   parameter int LAST_PC  = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   ifetch_ctrl_if.master bus,
   output logic          halted,
   output logic          err_misalign,
   output logic [15:0]   fetch_count
);

   fetch_state_e       state_q, state_d;
   logic               if_valid_q, if_valid_d;
   logic [INSTR_W-1:0] if_instr_q, if_instr_d;
   logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
   logic [ADDR_W-1:0]  if_pc4_q, if_pc4_d;
   logic               halted_q, halted_d;
   logic               err_q, err_d;
   logic [15:0]        fetch_count_q, fetch_count_d;

   logic [ADDR_W-1:0]  pc;
   logic               pc_load;
   logic               pc_inc;
   logic               accept;
   logic               slot_free;
   logic               pc_in_range;

   pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (pc_load),
      .load_val (bus.redirect_target),
      .inc      (pc_inc),
      .pc       (pc)
   );

   assign accept      = if_valid_q && bus.if_ready;
   assign slot_free   = !if_valid_q || bus.if_ready;
   assign pc_in_range = pc <= ADDR_W'(LAST_PC);

   always_comb begin
      state_d       = state_q;
      if_valid_d    = if_valid_q;
      if_instr_d    = if_instr_q;
      if_pc_d       = if_pc_q;
      if_pc4_d      = if_pc4_q;
      err_d         = err_q;
      pc_load       = 1'b0;
      pc_inc        = 1'b0;
      fetch_count_d = fetch_count_q + {15'd0, accept};

      // Redirect wins over everything outside IDLE, flushing even an accepted slot.
      if (state_q != ST_IDLE && bus.redirect_valid) begin
         if_valid_d = 1'b0;
         if (word_aligned(bus.redirect_target[1:0])) begin
            pc_load = 1'b1;
            state_d = ST_RUN;
         end else begin
            err_d   = 1'b1;
            state_d = ST_HALT;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (run) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (slot_free && pc_in_range) begin
                  if_valid_d = 1'b1;
                  if_instr_d = bus.imem_data;
                  if_pc_d    = pc;
                  if_pc4_d   = pc + ADDR_W'(4);
                  pc_inc     = 1'b1;
               end else if (slot_free) begin
                  if_valid_d = 1'b0;
                  state_d    = ST_HALT;
               end
            end
            ST_HALT: begin
               if (accept) if_valid_d = 1'b0;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      halted_d = (state_d == ST_HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         if_valid_q    <= 1'b0;
         if_instr_q    <= '0;
         if_pc_q       <= '0;
         if_pc4_q      <= '0;
         halted_q      <= 1'b0;
         err_q         <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         state_q       <= state_d;
         if_valid_q    <= if_valid_d;
         if_instr_q    <= if_instr_d;
         if_pc_q       <= if_pc_d;
         if_pc4_q      <= if_pc4_d;
         halted_q      <= halted_d;
         err_q         <= err_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign bus.imem_addr = pc;
   assign bus.if_valid  = if_valid_q;
   assign bus.if_instr  = if_instr_q;
   assign bus.if_pc     = if_pc_q;
   assign bus.if_pc4    = if_pc4_q;
   assign halted        = halted_q;
   assign err_misalign  = err_q;
   assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: fixed program table, hand sequences for stall,
// redirect, halt/resume, misalign and mid-run reset, then random traffic vs a model.
module tb_ifetch_ctrl;

   localparam int AW   = 7;
   localparam int LAST = 16;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        halted;
   logic        err_misalign;
   logic [15:0] fetch_count;

   int n_chk  = 0;
   int n_fail = 0;

   ifetch_ctrl_if #(.ADDR_W(AW)) bus ();

   ifetch_ctrl #(.ADDR_W(AW), .RESET_PC(0), .LAST_PC(LAST)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .run          (run),
      .bus          (bus),
      .halted       (halted),
      .err_misalign (err_misalign),
      .fetch_count  (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Big-endian program image, 20 bytes; addresses outside read as zero.
   function automatic logic [31:0] rom_word(input int a);
      case (a)
         0:       return 32'h8C02000E;
         4:       return 32'h41290002;
         8:       return 32'h00623020;
         12:      return 32'h00C23822;
         16:      return 32'h01043020;
         default: return 32'h0;
      endcase
   endfunction

   assign bus.imem_data = rom_word(int'(bus.imem_addr));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input bit v, input int pc, input logic [31:0] instr,
                          input bit h, input bit e, input int cnt, input int addr);
      chk({tag, ".valid"}, 32'(bus.if_valid), 32'(v));
      chk({tag, ".halted"}, 32'(halted), 32'(h));
      chk({tag, ".err"}, 32'(err_misalign), 32'(e));
      chk({tag, ".cnt"}, 32'(fetch_count), 32'(cnt));
      chk({tag, ".addr"}, 32'(bus.imem_addr), 32'(addr));
      if (v) begin
         chk({tag, ".pc"}, 32'(bus.if_pc), 32'(pc));
         chk({tag, ".instr"}, bus.if_instr, instr);
         chk({tag, ".pc4"}, 32'(bus.if_pc4), 32'((pc + 4) % 128));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      run = 1'b0;
      bus.if_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_target = '0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
   endtask

   // Reference model: spec rules in plain integers.
   int m_st;   // 0 idle, 1 run, 2 halt
   int m_pc, m_ipc, m_cnt;
   bit m_valid, m_err;
   logic [31:0] m_instr;

   task automatic model_reset();
      m_st = 0; m_pc = 0; m_ipc = 0; m_cnt = 0;
      m_valid = 0; m_err = 0; m_instr = '0;
   endtask

   task automatic model_step(input bit r, input bit rdy, input bit rv, input int tgt);
      bit acc;
      int nst;
      acc = m_valid && rdy;
      nst = m_st;
      if (acc) m_cnt = (m_cnt + 1) % 65536;
      if (m_st != 0 && rv) begin
         m_valid = 0;
         if (tgt % 4 == 0) begin
            m_pc = tgt;
            nst = 1;
         end else begin
            m_err = 1;
            nst = 2;
         end
      end else if (m_st == 0) begin
         if (r) nst = 1;
      end else if (m_st == 1) begin
         if (!m_valid || rdy) begin
            if (m_pc <= LAST) begin
               m_valid = 1;
               m_ipc = m_pc;
               m_instr = rom_word(m_pc);
               m_pc = (m_pc + 4) % 128;
            end else begin
               m_valid = 0;
               nst = 2;
            end
         end
      end else if (acc) begin
         m_valid = 0;
      end
      m_st = nst;
   endtask

   typedef struct {
      bit          run;
      bit          ready;
      bit          e_valid;
      int          e_pc;
      logic [31:0] e_instr;
      bit          e_halt;
      int          e_cnt;
      int          e_addr;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int tgts [10];
      tgts = '{0, 4, 8, 12, 16, 20, 124, 6, 2, 13};

      tbl[0] = '{1'b1, 1'b1, 1'b0, 0,  32'h0,        1'b0, 0, 0};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 0,  32'h8C02000E, 1'b0, 0, 4};
      tbl[2] = '{1'b1, 1'b1, 1'b1, 4,  32'h41290002, 1'b0, 1, 8};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 8,  32'h00623020, 1'b0, 2, 12};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 12, 32'h00C23822, 1'b0, 3, 16};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 16, 32'h01043020, 1'b0, 4, 20};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 0,  32'h0,        1'b1, 5, 20};
      tbl[7] = '{1'b0, 1'b1, 1'b0, 0,  32'h0,        1'b1, 5, 20};

      // Reset values and straight-line program run
      do_reset();
      chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
      chk("reset.pc", 32'(bus.if_pc), 0);
      chk("reset.instr", bus.if_instr, 0);
      chk("reset.pc4", 32'(bus.if_pc4), 0);
      for (int i = 0; i < 8; i++) begin
         run = tbl[i].run;
         bus.if_ready = tbl[i].ready;
         tick();
         chk_out($sformatf("tbl%0d", i), tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_instr,
                 tbl[i].e_halt, 1'b0, tbl[i].e_cnt, tbl[i].e_addr);
      end

      // Back-pressure holding pc=8
      do_reset();
      run = 1; bus.if_ready = 1;
      repeat (4) tick();
      chk_out("stall.pre", 1, 8, 32'h00623020, 0, 0, 2, 12);
      bus.if_ready = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out($sformatf("stall%0d", i), 1, 8, 32'h00623020, 0, 0, 2, 12);
      end
      bus.if_ready = 1;
      tick();
      chk_out("stall.rel", 1, 12, 32'h00C23822, 0, 0, 3, 16);

      // Redirect to 12 while pc=4 is accepted
      do_reset();
      run = 1; bus.if_ready = 1;
      repeat (3) tick();
      chk_out("redir.pre", 1, 4, 32'h41290002, 0, 0, 1, 8);
      bus.redirect_valid = 1; bus.redirect_target = 7'd12;
      tick();
      chk_out("redir.bubble", 0, 0, 0, 0, 0, 2, 12);
      bus.redirect_valid = 0;
      tick();
      chk_out("redir.tgt", 1, 12, 32'h00C23822, 0, 0, 2, 16);
      repeat (2) tick();
      chk_out("redir.halt", 0, 0, 0, 1, 0, 4, 20);
      tick();
      chk_out("halt.hold", 0, 0, 0, 1, 0, 4, 20);

      // Exit HALT by redirect to 0
      bus.redirect_valid = 1; bus.redirect_target = 7'd0;
      tick();
      chk_out("halt.exit", 0, 0, 0, 0, 0, 4, 0);
      bus.redirect_valid = 0;
      tick();
      chk_out("halt.resume", 1, 0, 32'h8C02000E, 0, 0, 4, 4);

      // Misaligned redirect, then aligned recovery
      bus.redirect_valid = 1; bus.redirect_target = 7'd6;
      tick();
      chk_out("mis.err", 0, 0, 0, 1, 1, 5, 4);
      bus.redirect_valid = 0;
      tick();
      chk_out("mis.sticky", 0, 0, 0, 1, 1, 5, 4);
      bus.redirect_valid = 1; bus.redirect_target = 7'd4;
      tick();
      chk_out("mis.redir", 0, 0, 0, 0, 1, 5, 4);
      bus.redirect_valid = 0;
      tick();
      chk_out("mis.resume", 1, 4, 32'h41290002, 0, 1, 5, 8);

      // Asynchronous reset with a stalled, valid slot
      do_reset();
      run = 1; bus.if_ready = 1;
      repeat (3) tick();
      bus.if_ready = 0;
      tick();
      chk_out("arst.pre", 1, 4, 32'h41290002, 0, 0, 1, 8);
      #1 rst_n = 0;
      #1;
      chk_out("arst.async", 0, 0, 0, 0, 0, 0, 0);
      chk("arst.pc", 32'(bus.if_pc), 0);
      chk("arst.instr", bus.if_instr, 0);
      chk("arst.pc4", 32'(bus.if_pc4), 0);
      tick();
      chk_out("arst.held", 0, 0, 0, 0, 0, 0, 0);
      #2 rst_n = 1;
      bus.if_ready = 1;
      tick();
      chk_out("arst.run", 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk_out("arst.refetch", 1, 0, 32'h8C02000E, 0, 0, 0, 4);

      // Random traffic against the model
      do_reset();
      model_reset();
      for (int i = 0; i < 600; i++) begin
         bit r, rdy, rv;
         int tgt;
         r = ($urandom_range(0, 9) != 0);
         rdy = ($urandom_range(0, 9) < 7);
         rv = ($urandom_range(0, 9) == 0);
         tgt = tgts[$urandom_range(0, 9)];
         run = r;
         bus.if_ready = rdy;
         bus.redirect_valid = rv;
         bus.redirect_target = AW'(tgt);
         model_step(r, rdy, rv, tgt);
         tick();
         chk_out($sformatf("rnd%0d", i), m_valid, m_ipc, m_instr, (m_st == 2), m_err, m_cnt, m_pc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch sequencer for the single-cycle MIPS-32 datapath. It owns the program counter and drives the read address of the byte-addressed instruction memory (`instMemory`). It registers the 32-bit big-endian word that the memory returns combinationally and presents it to decode through a valid/ready handshake. It also handles branch/jump redirects, decode back-pressure, end-of-program halt and misaligned-target errors.

## Interface
Parameters:
- ADDR_W, 7: PC and instruction-memory address width; all PC arithmetic is modulo 2^ADDR_W.
- RESET_PC, 0: PC value loaded at reset.
- LAST_PC, 16: highest word address holding a valid instruction (memory holds 20 bytes, so 5 words).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  leaves IDLE and starts fetching.
- imem_addr  out  ADDR_W  read address to instruction memory; equals the internal PC.
- imem_data  in  32  combinational instruction word from memory.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  ADDR_W  new PC for the redirect.
- if_valid  out  1  if_instr/if_pc hold a valid fetched instruction.
- if_ready  in  1  decode accepts this cycle.
- if_instr  out  32  fetched instruction.
- if_pc  out  ADDR_W  address of if_instr.
- if_pc4  out  ADDR_W  if_pc+4 (mod 2^ADDR_W).
- halted  out  1  FSM is in HALT.
- err_misalign  out  1  sticky; a redirect target had bits [1:0] != 0.
- fetch_count  out  16  number of instructions accepted by decode; wraps at 2^16.

## Operation
- States: IDLE, RUN, HALT.
- IDLE → RUN when run=1. No fetch occurs in IDLE.
- **Fetch in RUN.** When PC <= LAST_PC and the output slot is free or being consumed (!if_valid || if_ready):
  - load if_instr←imem_data, if_pc←PC, if_pc4←PC+4, if_valid←1;
  - PC←PC+4.
- **Stall.** When if_valid && !if_ready: PC, if_instr, if_pc and if_pc4 hold exactly. No fetch.
- **Slot drains.** When if_valid && if_ready and no new fetch is possible (PC > LAST_PC): if_valid←0.
- **End of program.** In RUN with PC > LAST_PC and the slot empty or being consumed: go to HALT.
- **Redirect.** redirect_valid=1 has priority over every other event, in any state except IDLE:
  - if_valid←0 (flushes any held instruction, even one accepted this same cycle; fetch_count still increments on that acceptance);
  - if target[1:0]==0: PC←target and state←RUN (this also exits HALT);
  - otherwise: err_misalign←1, state←HALT, PC unchanged.
- redirect_valid in IDLE is ignored.
- fetch_count increments on every cycle where if_valid && if_ready.
- The misaligned-PC check applies only to redirect targets. RESET_PC must be word aligned.

## Timing
- Reset (asynchronous assert, synchronous-safe release) gives: state=IDLE, PC=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc4=0, halted=0, err_misalign=0, fetch_count=0.
- Reset asserted mid-operation discards the held instruction immediately.
- Latency: run sampled high at cycle N → first fetch at N+1 → if_valid=1 at N+2.
- Throughput: one instruction per cycle while if_ready=1.
- Redirect sampled at cycle N → if_valid=0 during N+1, fetch from target in N+1 → target instruction valid at N+2. This is one bubble.
- imem_addr changes only on clock edges, so imem_data is stable for a full cycle.
- halted is a registered output: high in the cycle after entering HALT.
- if_pc4 wraps; e.g. PC 124 → 0.

## Structure
- Shared package `mips_pkg`: ADDR_W default, instruction word width (32), and the FSM state enum.
- One natural sub-module: `pc_reg`. It holds the PC with load (redirect), increment and hold controls. The FSM, output slot and counter stay in the top level.

## Test plan
- Reset, run=1, if_ready=1 → if_pc sequence 0,4,8,12,16 with if_instr 0x8C02000E, 0x41290002, 0x00623020, 0x00C23822, 0x01043020; then halted=1 and fetch_count=5.
- if_ready=0 for 3 cycles while if_pc=8 → if_instr holds 0x00623020 and imem_addr holds 12; after release, the next instruction is if_pc=12.
- redirect_valid with target=12 on the cycle if_pc=4 is accepted → if_valid=0 for one cycle, then if_pc=12 / 0x00C23822; fetch_count counts the pc=4 acceptance.
- In HALT, redirect to 0 → state RUN, halted=0, if_pc=0 / 0x8C02000E two cycles later.
- Redirect to 6 → err_misalign=1 (sticky), halted=1, if_valid=0; a later aligned redirect to 4 resumes fetching while err_misalign stays 1.
- rst_n pulsed low while if_valid=1 and if_ready=0 → all outputs return to reset values asynchronously; with run held high, fetch restarts at pc 0.
